rd_ws_responder: RTL
====================

# rd_ws_responder

Read target for the `rd`/`ws`/`ds` read handshake. It answers an initiator that raises `rd`, stretches the access with `ws` for a programmable number of cycles, and presents read data from a local 16x8 register array. It finishes the transfer when the initiator pulses `ds`. The block sits on the target side of the bus and has a local write port so the array can be preloaded.

## Interface
- `AW`, 4, address width; array depth is 2^AW.
- `DW`, 8, data width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rd`  in  1  read request from the initiator; held high for the whole access.
- `ds`  in  1  done strobe from the initiator; a one-cycle pulse that completes the access.
- `addr`  in  AW  read address; sampled when the access starts.
- `wait_cfg`  in  4  number of wait-state cycles (0..15); sampled when the access starts.
- `wr_en`  in  1  local write enable.
- `wr_addr`  in  AW  local write address.
- `wr_data`  in  DW  local write data.
- `ws`  out  1  wait-state; high means the initiator must keep retrying.
- `rdata`  out  DW  read data; valid while `rvalid` is high.
- `rvalid`  out  1  high while the block is in HOLD.
- `busy`  out  1  high in any state other than IDLE.
- `err_abort`  out  1  one-cycle pulse when an access is abandoned.
- `access_cnt`  out  8  count of completed accesses; wraps from 255 to 0.

## Operation
- States:
  - IDLE: `ws`=0, `rvalid`=0, `busy`=0.
  - WAIT: `ws`=1, `busy`=1.
  - HOLD: `ws`=0, `rvalid`=1, `busy`=1.
- IDLE, `rd`=1 sampled:
  - Latch `addr` into `addr_q` and `wait_cfg` into `cnt`.
  - If `wait_cfg`≠0, go to WAIT with `ws`<=1.
  - If `wait_cfg`=0, go to HOLD, load `rdata`<=`mem[addr]`, `rvalid`<=1.
- IDLE, `ds`=1 alone: ignored.
- WAIT, `rd`=1:
  - If `cnt`>1, decrement `cnt`.
  - If `cnt`==1, go to HOLD with `ws`<=0, `rdata`<=`mem[addr_q]`, `rvalid`<=1.
- WAIT, `rd`=0: abort. Pulse `err_abort`, `ws`<=0, return to IDLE, `access_cnt` unchanged.
- HOLD, `ds`=1 (regardless of `rd`): go to IDLE, `rvalid`<=0, `access_cnt`<=`access_cnt`+1.
- HOLD, `rd`=1 and `ds`=0: stay in HOLD; the initiator may still be in its retry phase. `rdata` is held stable.
- HOLD, `rd`=0 and `ds`=0: abort. Pulse `err_abort`, return to IDLE, `rvalid`<=0.
- Changes on `addr` or `wait_cfg` after the access starts have no effect on that access.
- Array:
  - `mem[wr_addr]`<=`wr_data` on any cycle with `wr_en`=1, in every state.
  - A read capture samples the pre-edge contents. A write on the same edge as the capture returns the old value; a write on any earlier cycle is visible.
- Reset values: `ws`, `rvalid`, `busy`, `err_abort` = 0; `rdata`, `access_cnt`, `cnt`, `addr_q` = 0; all `mem` entries = 0; state = IDLE. Reset asserted mid-access forces these values immediately, with no `err_abort` pulse.

## Timing
- All outputs are registered.
- `ws` is high for exactly `wait_cfg` cycles, starting the cycle after the edge that samples `rd`=1.
- With `rd` first sampled at edge P1 and N=`wait_cfg`:
  - `ws`=1 during [P1, P1+N).
  - `rvalid`=1 and `rdata` valid from edge P1+N.
  - N=0 gives `rvalid` at P1 and `ws` is never asserted.
- With the standard initiator (N=2): initiator `ds` high [P4, P5); responder returns to IDLE at P5 and `access_cnt` increments at P5.
- `err_abort` is high for exactly one cycle, following the edge that detects the abort.
- Back-to-back accesses: a new `rd` sampled on the edge after the return to IDLE starts the next access, with no dead cycle required.

## Test plan
- Preload `mem[3]`=0xA5, N=2, `addr`=3, standard initiator sequence -> `ws` high 2 cycles; `rdata`=0xA5 with `rvalid` until `ds`; `access_cnt` 0->1.
- N=0, `addr`=7, `mem[7]`=0x3C -> `ws` never asserted; `rvalid` on the edge after `rd` sampled; completes on `ds`.
- N=5, drop `rd` on the 3rd WAIT cycle -> single-cycle `err_abort`, IDLE, `access_cnt` unchanged, `rvalid` stays 0.
- N=3, `addr`=2; write `mem[2]`=0x11 during WAIT cycle 1 -> `rdata`=0x11. Write 0x22 on the capture edge -> `rdata`=0x11 (old value).
- Run 256 completed accesses -> `access_cnt` wraps to 0. Change `addr`/`wait_cfg` mid-WAIT -> no effect on the current access.
- Assert `rst_n`=0 while in HOLD -> all outputs 0 and `mem` cleared immediately; after release, the first `rd` starts a normal access.

Source files
------------

// File: rtl/rd_ws_responder.sv
// Read target for the rd/ws/ds handshake: stretches each access by a programmable
// number of wait states, then presents data from a locally writable register array.
module rd_ws_responder #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic          ds,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    wait_cfg,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          ws,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          busy,
  output logic          err_abort,
  output logic [7:0]    access_cnt
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array is cleared by reset, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: non-blocking updates mean the captures below see pre-edge array contents,
  // so a write on the capture edge returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      ws         <= 1'b0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      busy       <= 1'b0;
      err_abort  <= 1'b0;
      access_cnt <= '0;
    end else begin
      err_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd) begin
            addr_q <= addr;
            cnt    <= wait_cfg;
            busy   <= 1'b1;
            if (wait_cfg != 4'd0) begin
              state <= S_WAIT;
              ws    <= 1'b1;
            end else begin
              state  <= S_HOLD;
              rdata  <= mem[addr];
              rvalid <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (!rd) begin
            state     <= S_IDLE;
            ws        <= 1'b0;
            busy      <= 1'b0;
            err_abort <= 1'b1;
          end else if (cnt > 4'd1) begin
            cnt <= cnt - 4'd1;
          end else begin
            state  <= S_HOLD;
            ws     <= 1'b0;
            rdata  <= mem[addr_q];
            rvalid <= 1'b1;
          end
        end

        S_HOLD: begin
          if (ds) begin
            state      <= S_IDLE;
            rvalid     <= 1'b0;
            busy       <= 1'b0;
            access_cnt <= access_cnt + 8'd1;
          end else if (!rd) begin
            state     <= S_IDLE;
            rvalid    <= 1'b0;
            busy      <= 1'b0;
            err_abort <= 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          ws     <= 1'b0;
          rvalid <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
